// File: rtl/toggle_burst_checker.sv
// ============================================================================
// Module      : toggle_burst_checker
// Description : Counts per-line toggles of a two-signal burst, closes a burst
//               on inactivity and reports a pass/fail verdict with error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_burst_checker #(
  parameter int unsigned EXP_TOGGLES  = 10,
  parameter int unsigned IDLE_TIMEOUT = 4,
  parameter int unsigned MAX_SKEW     = 1,
  parameter int unsigned CW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig1,
  input  logic          sig2,
  input  logic          clear,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [3:0]    err,
  output logic [CW-1:0] tog1_cnt,
  output logic [CW-1:0] tog2_cnt,
  output logic [CW-1:0] burst_cnt
);

  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(MAX_SKEW + 2);

  localparam logic [TW-1:0] c_timeout   = TW'(IDLE_TIMEOUT);
  localparam logic [SW-1:0] c_max_skew  = SW'(MAX_SKEW);
  localparam logic [SW-1:0] c_skew_sat  = SW'(MAX_SKEW + 1);
  localparam logic [CW-1:0] c_exp       = CW'(EXP_TOGGLES);
  localparam logic [CW-1:0] c_cnt_max   = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_CHECK  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_s1_q;
  logic          r_s2_q;
  logic [TW-1:0] r_tmr;
  logic [SW-1:0] r_skew;

  logic          w_e1;
  logic          w_e2;
  logic          w_any;
  logic [TW-1:0] w_tmr_inc;
  logic [SW-1:0] w_skew_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && (v != c_cnt_max)) ? v + CW'(1) : v;
  endfunction

  assign w_e1      = sig1 ^ r_s1_q;
  assign w_e2      = sig2 ^ r_s2_q;
  assign w_any     = w_e1 | w_e2;
  assign w_tmr_inc = r_tmr + TW'(1);
  // Skew run length saturates just above the limit; only "exceeded" matters.
  assign w_skew_nxt = (r_s1_q == r_s2_q)
                      ? ((r_skew == c_skew_sat) ? r_skew : r_skew + SW'(1))
                      : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_s1_q    <= 1'b0;
      r_s2_q    <= 1'b1;
      r_tmr     <= '0;
      r_skew    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err       <= '0;
      tog1_cnt  <= '0;
      tog2_cnt  <= '0;
      burst_cnt <= '0;
    end else if (clear) begin
      r_state   <= S_IDLE;
      r_s1_q    <= sig1;
      r_s2_q    <= sig2;
      r_tmr     <= '0;
      r_skew    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err       <= '0;
      tog1_cnt  <= '0;
      tog2_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      r_s1_q <= sig1;
      r_s2_q <= sig2;
      done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_ACTIVE;
            busy     <= 1'b1;
            tog1_cnt <= CW'(w_e1);
            tog2_cnt <= CW'(w_e2);
            err      <= '0;
            pass     <= 1'b0;
            r_tmr    <= '0;
            r_skew   <= '0;
          end
        end
        S_ACTIVE: begin
          tog1_cnt <= sat_inc(tog1_cnt, w_e1);
          tog2_cnt <= sat_inc(tog2_cnt, w_e2);
          r_skew   <= w_skew_nxt;
          if (w_skew_nxt > c_max_skew) begin
            err[2] <= 1'b1;
          end
          if (w_any) begin
            r_tmr <= '0;
          end else begin
            r_tmr <= w_tmr_inc;
            if (w_tmr_inc == c_timeout) begin
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          err[0] <= (tog1_cnt != c_exp);
          err[1] <= (tog2_cnt != c_exp);
          if (w_any) begin
            err[3] <= 1'b1;
          end
          r_state <= S_REPORT;
          done    <= 1'b1;
        end
        S_REPORT: begin
          // Verdict uses the flags as registered; an edge seen now lands after it.
          pass      <= (err == 4'b0000);
          burst_cnt <= sat_inc(burst_cnt, 1'b1);
          if (w_any) begin
            err[3] <= 1'b1;
          end
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_toggle_burst_checker.sv
// ============================================================================
// Module      : tb_toggle_burst_checker
// Description : Self-checking bench for toggle_burst_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toggle_burst_checker;

  localparam int unsigned EXP_TOGGLES  = 10;
  localparam int unsigned IDLE_TIMEOUT = 4;
  localparam int unsigned MAX_SKEW     = 1;
  localparam int unsigned CW           = 8;

  typedef bit [1:0] pat_q_t[$];  // bit0 toggles sig1, bit1 toggles sig2

  typedef struct {
    string      name;
    int         pre;
    int         gap;
    int         post;
    int         only2;
    int         x1;
    int         x2;
    logic [3:0] xe;
    logic       xp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          sig1;
  logic          sig2;
  logic          clear;
  logic          busy;
  logic          done;
  logic          pass;
  logic [3:0]    err;
  logic [CW-1:0] tog1_cnt;
  logic [CW-1:0] tog2_cnt;
  logic [CW-1:0] burst_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int n_done  = 0;
  int done_cyc = 0;
  int exp_bursts = 0;
  logic [CW-1:0] d_t1, d_t2;
  logic [3:0]    d_err;
  bit l1, l2;
  vec_t tbl[5];

  toggle_burst_checker #(
    .EXP_TOGGLES (EXP_TOGGLES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .MAX_SKEW    (MAX_SKEW),
    .CW          (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig1     (sig1),
    .sig2     (sig2),
    .clear    (clear),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err      (err),
    .tog1_cnt (tog1_cnt),
    .tog2_cnt (tog2_cnt),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, observe 1 time unit after posedge.
  task automatic cyc(input bit a, input bit b, input bit c);
    @(negedge clk);
    sig1  = a;
    sig2  = b;
    clear = c;
    @(posedge clk);
    #1;
    cycle++;
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cycle;
      d_t1  = tog1_cnt;
      d_t2  = tog2_cnt;
      d_err = err;
    end
  endtask

  task automatic tog(input bit e1, input bit e2);
    l1 = l1 ^ e1;
    l2 = l2 ^ e2;
    cyc(l1, l2, 1'b0);
  endtask

  function automatic vec_t mk(input string n, input int pre, input int gap, input int post,
                              input int only2, input int x1, input int x2,
                              input logic [3:0] xe, input logic xp);
    vec_t v;
    v.name = n; v.pre = pre; v.gap = gap; v.post = post; v.only2 = only2;
    v.x1 = x1; v.x2 = x2; v.xe = xe; v.xp = xp;
    return v;
  endfunction

  // Reference: counts are edge totals; phase error is any run of equal levels
  // longer than MAX_SKEW from the first edge until the idle timer expires.
  function automatic void model(input pat_q_t q, input bit a0, input bit b0,
                                output int t1, output int t2, output logic [3:0] e);
    bit a, b;
    int run, worst;
    a = a0; b = b0; run = 0; worst = 0; t1 = 0; t2 = 0;
    foreach (q[i]) begin
      a = a ^ q[i][0];
      b = b ^ q[i][1];
      t1 += int'(q[i][0]);
      t2 += int'(q[i][1]);
      run = (a == b) ? run + 1 : 0;
      if (run > worst) worst = run;
    end
    for (int k = 0; k < int'(IDLE_TIMEOUT) - 1; k++) begin
      run = (a == b) ? run + 1 : 0;
      if (run > worst) worst = run;
    end
    if (t1 > 255) t1 = 255;
    if (t2 > 255) t2 = 255;
    e = {1'b0, worst > int'(MAX_SKEW), t2 != int'(EXP_TOGGLES), t1 != int'(EXP_TOGGLES)};
  endfunction

  task automatic run_burst(input string nm, input pat_q_t q, input int x1, input int x2,
                           input logic [3:0] xe, input logic xp);
    int base, lc;
    base = n_done;
    lc = cycle;
    foreach (q[i]) begin
      tog(q[i][0], q[i][1]);
      if (q[i] != 2'b00) lc = cycle;
    end
    repeat (IDLE_TIMEOUT + 4) tog(1'b0, 1'b0);
    exp_bursts++;
    chk({nm, " done_count"}, n_done - base, 1);
    chk({nm, " done_latency"}, done_cyc - lc, IDLE_TIMEOUT + 1);
    chk({nm, " tog1_cnt"}, d_t1, x1);
    chk({nm, " tog2_cnt"}, d_t2, x2);
    chk({nm, " err"}, d_err, xe);
    chk({nm, " pass"}, pass, xp);
    chk({nm, " burst_cnt"}, burst_cnt, exp_bursts);
    chk({nm, " busy_after"}, busy, 0);
  endtask

  task automatic run_model(input string nm, input pat_q_t q);
    int x1, x2;
    logic [3:0] xe;
    model(q, l1, l2, x1, x2, xe);
    run_burst(nm, q, x1, x2, xe, xe == 4'b0000);
  endtask

  // Return the lines to their idle levels (sig1=0, sig2=1) with a short burst.
  task automatic restore();
    pat_q_t q;
    if (l1 != 1'b0 || l2 != 1'b1) begin
      q.push_back({~l2, l1});
      run_model("restore", q);
    end
  endtask

  function automatic pat_q_t nominal();
    pat_q_t q;
    repeat (10) q.push_back(2'b11);
    return q;
  endfunction

  task automatic overrun_case(input string nm, input int off, input logic xp, input logic [3:0] xe_done);
    int base, lc;
    base = n_done;
    repeat (10) tog(1'b1, 1'b1);
    lc = cycle;
    repeat (off - 1) tog(1'b0, 1'b0);
    tog(1'b1, 1'b1);
    repeat (IDLE_TIMEOUT + 4) tog(1'b0, 1'b0);
    exp_bursts++;
    chk({nm, " done_count"}, n_done - base, 1);
    chk({nm, " done_latency"}, done_cyc - lc, IDLE_TIMEOUT + 1);
    chk({nm, " tog1_at_done"}, d_t1, 10);
    chk({nm, " err_at_done"}, d_err, xe_done);
    chk({nm, " err_idle"}, err, 4'b1000);
    chk({nm, " pass"}, pass, xp);
    chk({nm, " burst_cnt"}, burst_cnt, exp_bursts);
  endtask

  initial begin
    pat_q_t q;
    int base, mode, len, zr, idx;
    bit [1:0] v;

    tbl[0] = mk("nominal", 10, 0, 0, 0, 10, 10, 4'b0000, 1'b1);
    tbl[1] = mk("gap",     10, 3, 2, 0, 12, 12, 4'b0011, 1'b0);
    tbl[2] = mk("short8",   8, 0, 0, 2,  8, 10, 4'b0001, 1'b0);
    tbl[3] = mk("count11", 11, 0, 0, 0, 11, 11, 4'b0011, 1'b0);
    // Odd sig1 count leaves both lines equal while the idle timer runs.
    tbl[4] = mk("short9",   9, 0, 0, 1,  9, 10, 4'b0101, 1'b0);

    rst = 1'b0; sig1 = 1'b0; sig2 = 1'b1; clear = 1'b0; l1 = 1'b0; l2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset pass", pass, 0);
    chk("reset err", err, 0);
    chk("reset tog1", tog1_cnt, 0);
    chk("reset burst_cnt", burst_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    base = n_done;
    repeat (3) tog(1'b0, 1'b0);
    chk("post-reset idle busy", busy, 0);
    chk("post-reset no done", n_done - base, 0);

    foreach (tbl[i]) begin
      q = {};
      repeat (tbl[i].pre)   q.push_back(2'b11);
      repeat (tbl[i].gap)   q.push_back(2'b00);
      repeat (tbl[i].post)  q.push_back(2'b11);
      repeat (tbl[i].only2) q.push_back(2'b10);
      run_burst(tbl[i].name, q, tbl[i].x1, tbl[i].x2, tbl[i].xe, tbl[i].xp);
    end
    restore();

    q = {};
    repeat (5) q.push_back(2'b11);
    q.push_back(2'b10);
    repeat (2) q.push_back(2'b00);
    q.push_back(2'b01);
    repeat (4) q.push_back(2'b11);
    run_burst("phase", q, 10, 10, 4'b0100, 1'b0);

    overrun_case("overrun_check", IDLE_TIMEOUT + 1, 1'b0, 4'b1000);
    restore();
    overrun_case("overrun_report", IDLE_TIMEOUT + 2, 1'b1, 4'b0000);
    restore();

    // Asynchronous reset in the middle of a burst.
    repeat (5) tog(1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset tog1", tog1_cnt, 0);
    chk("midreset burst_cnt", burst_cnt, 0);
    @(negedge clk);
    sig1 = 1'b0; sig2 = 1'b1; l1 = 1'b0; l2 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    exp_bursts = 0;
    run_burst("after_reset", nominal(), 10, 10, 4'b0000, 1'b1);

    // Clear aborts an open burst without a verdict.
    base = n_done;
    repeat (3) tog(1'b1, 1'b1);
    cyc(l1, l2, 1'b1);
    repeat (IDLE_TIMEOUT + 4) tog(1'b0, 1'b0);
    chk("abort no done", n_done - base, 0);
    chk("abort busy", busy, 0);
    chk("abort tog1", tog1_cnt, 0);
    exp_bursts = 0;
    restore();
    run_burst("pre_clear_a", nominal(), 10, 10, 4'b0000, 1'b1);
    run_burst("pre_clear_b", nominal(), 10, 10, 4'b0000, 1'b1);
    base = n_done;
    cyc(l1, l2, 1'b1);
    chk("clear burst_cnt", burst_cnt, 0);
    chk("clear pass", pass, 0);
    chk("clear err", err, 0);
    repeat (IDLE_TIMEOUT + 4) tog(1'b0, 1'b0);
    chk("clear no done", n_done - base, 0);
    exp_bursts = 0;
    run_burst("after_clear", nominal(), 10, 10, 4'b0000, 1'b1);

    for (int r = 0; r < 30; r++) begin
      q = {};
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        for (int k = 0; k < 10; k++) begin
          q.push_back(2'b11);
          if (k < 9) repeat ($urandom_range(0, IDLE_TIMEOUT - 1)) q.push_back(2'b00);
        end
      end else if (mode == 1) begin
        len = int'($urandom_range(6, 14));
        zr = 0;
        for (int k = 0; k < len; k++) begin
          v = (k == 0 || k == len - 1) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
          if (v == 2'b00 && zr == int'(IDLE_TIMEOUT) - 1) v = 2'b11;
          zr = (v == 2'b00) ? zr + 1 : 0;
          q.push_back(v);
        end
      end else begin
        idx = int'($urandom_range(0, 9));
        for (int k = 0; k < 10; k++)
          q.push_back((k == idx) ? 2'($urandom_range(1, 2)) : 2'b11);
      end
      run_model("random", q);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
